// File: rtl/id_stage_pipe.sv
// id_stage_pipe: instruction decode for the openMips integer subset.
// Decodes logic/shift/add-sub/LUI/immediate forms, resolves operands
// with EX/MEM forwarding, stalls on load-use hazards, and registers the
// decoded result into the ID/EX register.
// The ID/EX register uses valid/ready handshakes on both sides and has a flush.
module id_stage_pipe #(
    parameter int DATA_W        = 32,
    parameter int PC_W          = 32,
    parameter int FWD_EN        = 1,
    parameter int LOAD_STALL_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [PC_W-1:0]   pc_i,
    input  logic [31:0]       inst_i,
    output logic [4:0]        rf_raddr_a_o,
    output logic [4:0]        rf_raddr_b_o,
    output logic              rf_re_a_o,
    output logic              rf_re_b_o,
    input  logic [DATA_W-1:0] rf_rdata_a_i,
    input  logic [DATA_W-1:0] rf_rdata_b_i,
    input  logic              ex_we_i,
    input  logic              ex_load_i,
    input  logic [4:0]        ex_waddr_i,
    input  logic [DATA_W-1:0] ex_wdata_i,
    input  logic              mem_we_i,
    input  logic [4:0]        mem_waddr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [PC_W-1:0]   pc_o,
    output logic [DATA_W-1:0] op_a_o,
    output logic [DATA_W-1:0] op_b_o,
    output logic              we_o,
    output logic [4:0]        waddr_o,
    output logic [2:0]        alu_sel_o,
    output logic [7:0]        alu_op_o,
    output logic              inst_valid_o
);

    localparam logic [2:0] SEL_NOP   = 3'd0;
    localparam logic [2:0] SEL_LOGIC = 3'd1;
    localparam logic [2:0] SEL_SHIFT = 3'd2;
    localparam logic [2:0] SEL_ARITH = 3'd3;

    logic [5:0]  opc;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sa;
    logic [15:0] imm;

    assign opc   = inst_i[31:26];
    assign rs    = inst_i[25:21];
    assign rt    = inst_i[20:16];
    assign rd    = inst_i[15:11];
    assign sa    = inst_i[10:6];
    assign funct = inst_i[5:0];
    assign imm   = inst_i[15:0];

    logic              dec_ok;
    logic [2:0]        dec_sel;
    logic [7:0]        dec_op;
    logic [4:0]        dec_waddr;
    logic              dec_wr;
    logic              re_a;
    logic              re_b;
    logic [DATA_W-1:0] imm_a;
    logic [DATA_W-1:0] imm_b;

    // Instruction decode: ALU class/op, write target, and which sources come from registers.
    always_comb begin
        dec_ok    = 1'b0;
        dec_sel   = SEL_NOP;
        dec_op    = 8'h00;
        dec_waddr = 5'd0;
        dec_wr    = 1'b0;
        re_a      = 1'b0;
        re_b      = 1'b0;
        imm_a     = '0;
        imm_b     = '0;
        case (opc)
            6'h00: begin
                case (funct)
                    6'h24, 6'h25, 6'h26, 6'h27: begin
                        dec_ok  = 1'b1;
                        dec_sel = SEL_LOGIC;
                        dec_op  = {2'b00, funct};
                        re_a    = 1'b1;
                        re_b    = 1'b1;
                    end
                    6'h21, 6'h23, 6'h2A: begin
                        dec_ok  = 1'b1;
                        dec_sel = SEL_ARITH;
                        dec_op  = {2'b00, funct};
                        re_a    = 1'b1;
                        re_b    = 1'b1;
                    end
                    6'h00, 6'h02, 6'h03: begin
                        dec_ok  = 1'b1;
                        dec_sel = SEL_SHIFT;
                        // SLL has function code 0, so it gets a distinct op code
                        dec_op  = (funct == 6'h00) ? 8'h7C : {2'b00, funct};
                        re_b    = 1'b1;
                        imm_a   = DATA_W'(sa);
                    end
                    default: ;
                endcase
                dec_wr    = dec_ok;
                dec_waddr = dec_ok ? rd : 5'd0;
            end
            6'h0C, 6'h0D, 6'h0E: begin
                dec_ok    = 1'b1;
                dec_sel   = SEL_LOGIC;
                dec_op    = (opc == 6'h0C) ? 8'h24 : ((opc == 6'h0D) ? 8'h25 : 8'h26);
                re_a      = 1'b1;
                imm_b     = DATA_W'(imm);
                dec_wr    = 1'b1;
                dec_waddr = rt;
            end
            6'h09: begin
                dec_ok    = 1'b1;
                dec_sel   = SEL_ARITH;
                dec_op    = 8'h21;
                re_a      = 1'b1;
                imm_b     = DATA_W'($signed(imm));
                dec_wr    = 1'b1;
                dec_waddr = rt;
            end
            6'h0F: begin
                // LUI is an OR with a zero first operand
                dec_ok    = 1'b1;
                dec_sel   = SEL_LOGIC;
                dec_op    = 8'h25;
                imm_b     = DATA_W'({imm, 16'h0000});
                dec_wr    = 1'b1;
                dec_waddr = rt;
            end
            default: ;
        endcase
    end

    assign rf_raddr_a_o = rs;
    assign rf_raddr_b_o = rt;
    assign rf_re_a_o    = re_a;
    assign rf_re_b_o    = re_b;

    logic hit_ex_a;
    logic hit_ex_b;
    logic hit_mem_a;
    logic hit_mem_b;

    assign hit_ex_a  = re_a && (rs != 5'd0) && ex_we_i  && (ex_waddr_i  == rs);
    assign hit_ex_b  = re_b && (rt != 5'd0) && ex_we_i  && (ex_waddr_i  == rt);
    assign hit_mem_a = re_a && (rs != 5'd0) && mem_we_i && (mem_waddr_i == rs);
    assign hit_mem_b = re_b && (rt != 5'd0) && mem_we_i && (mem_waddr_i == rt);

    logic [DATA_W-1:0] opnd_a;
    logic [DATA_W-1:0] opnd_b;

    // Source A: EX result beats MEM result beats register file; r0 reads as zero.
    always_comb begin
        opnd_a = imm_a;
        if (re_a) begin
            if (rs == 5'd0)
                opnd_a = '0;
            else if ((FWD_EN != 0) && hit_ex_a)
                opnd_a = ex_wdata_i;
            else if ((FWD_EN != 0) && hit_mem_a)
                opnd_a = mem_wdata_i;
            else
                opnd_a = rf_rdata_a_i;
        end
    end

    // Source B: same priority as source A.
    always_comb begin
        opnd_b = imm_b;
        if (re_b) begin
            if (rt == 5'd0)
                opnd_b = '0;
            else if ((FWD_EN != 0) && hit_ex_b)
                opnd_b = ex_wdata_i;
            else if ((FWD_EN != 0) && hit_mem_b)
                opnd_b = mem_wdata_i;
            else
                opnd_b = rf_rdata_b_i;
        end
    end

    logic stall_load;
    logic stall_nofwd;
    logic stall;
    logic advance;
    logic accept;

    // A load result is not available until MEM, so a dependent instruction waits one cycle.
    // Without forwarding, any pending EX/MEM write to a source must retire first.
    assign stall_load  = (LOAD_STALL_EN != 0) && ex_load_i && (hit_ex_a || hit_ex_b);
    assign stall_nofwd = (FWD_EN == 0) && (hit_ex_a || hit_ex_b || hit_mem_a || hit_mem_b);
    assign stall       = in_valid_i && (stall_load || stall_nofwd);

    assign advance    = !out_valid_o || out_ready_i;
    assign in_ready_o = advance && !stall && !flush_i;
    assign accept     = in_valid_i && in_ready_o;

    // ID/EX register: reset/flush clear it, otherwise load or bubble when downstream can take it.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            out_valid_o  <= 1'b0;
            pc_o         <= '0;
            op_a_o       <= '0;
            op_b_o       <= '0;
            we_o         <= 1'b0;
            waddr_o      <= 5'd0;
            alu_sel_o    <= SEL_NOP;
            alu_op_o     <= 8'h00;
            inst_valid_o <= 1'b0;
        end else if (advance) begin
            if (accept) begin
                out_valid_o  <= 1'b1;
                pc_o         <= pc_i;
                op_a_o       <= opnd_a;
                op_b_o       <= opnd_b;
                we_o         <= dec_wr && (dec_waddr != 5'd0);
                waddr_o      <= dec_waddr;
                alu_sel_o    <= dec_sel;
                alu_op_o     <= dec_op;
                inst_valid_o <= dec_ok;
            end else begin
                out_valid_o  <= 1'b0;
                pc_o         <= '0;
                op_a_o       <= '0;
                op_b_o       <= '0;
                we_o         <= 1'b0;
                waddr_o      <= 5'd0;
                alu_sel_o    <= SEL_NOP;
                alu_op_o     <= 8'h00;
                inst_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: directed scenarios plus randomized traffic for the
// decode stage, checked every cycle against a behavioural model.
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] pc_i;
    logic [31:0] inst_i;
    logic [4:0]  rf_raddr_a_o, rf_raddr_b_o;
    logic        rf_re_a_o, rf_re_b_o;
    logic [31:0] rf_rdata_a_i, rf_rdata_b_i;
    logic        ex_we_i, ex_load_i;
    logic [4:0]  ex_waddr_i;
    logic [31:0] ex_wdata_i;
    logic        mem_we_i;
    logic [4:0]  mem_waddr_i;
    logic [31:0] mem_wdata_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] pc_o, op_a_o, op_b_o;
    logic        we_o;
    logic [4:0]  waddr_o;
    logic [2:0]  alu_sel_o;
    logic [7:0]  alu_op_o;
    logic        inst_valid_o;

    id_stage_pipe dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .pc_i(pc_i), .inst_i(inst_i),
        .rf_raddr_a_o(rf_raddr_a_o), .rf_raddr_b_o(rf_raddr_b_o),
        .rf_re_a_o(rf_re_a_o), .rf_re_b_o(rf_re_b_o),
        .rf_rdata_a_i(rf_rdata_a_i), .rf_rdata_b_i(rf_rdata_b_i),
        .ex_we_i(ex_we_i), .ex_load_i(ex_load_i),
        .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
        .mem_we_i(mem_we_i), .mem_waddr_i(mem_waddr_i), .mem_wdata_i(mem_wdata_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .pc_o(pc_o), .op_a_o(op_a_o), .op_b_o(op_b_o),
        .we_o(we_o), .waddr_o(waddr_o),
        .alu_sel_o(alu_sel_o), .alu_op_o(alu_op_o), .inst_valid_o(inst_valid_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit known = 0;

    // Meaning of an instruction: ALU class/op, which fields feed which operand.
    typedef struct {
        bit         ok;
        logic [2:0] sel;
        logic [7:0] op;
        bit         ra;      // rs comes from a register
        bit         rb;      // rt comes from a register
        int         wsrc;    // 0 none, 1 rd, 2 rt
        int         bkind;   // 0 register/none, 1 zero-ext imm, 2 sign-ext imm, 3 imm<<16
        bit         a_sa;    // op_a is the shift amount
    } dec_t;

    typedef struct {
        bit          v;
        logic [31:0] pc, a, b;
        bit          we;
        logic [4:0]  wa;
        logic [2:0]  sel;
        logic [7:0]  op;
        bit          iv;
    } exp_t;

    exp_t exp_q;
    exp_t empty_e;

    function automatic dec_t decode(input logic [31:0] w);
        dec_t d;
        logic [5:0] opc;
        logic [5:0] fn;
        d = '{default: 0};
        opc = w[31:26];
        fn  = w[5:0];
        if (opc == 6'h00) begin
            if (fn inside {6'h24, 6'h25, 6'h26, 6'h27}) begin
                d.ok = 1; d.sel = 3'd1; d.op = {2'b00, fn}; d.ra = 1; d.rb = 1; d.wsrc = 1;
            end else if (fn inside {6'h21, 6'h23, 6'h2A}) begin
                d.ok = 1; d.sel = 3'd3; d.op = {2'b00, fn}; d.ra = 1; d.rb = 1; d.wsrc = 1;
            end else if (fn inside {6'h00, 6'h02, 6'h03}) begin
                d.ok = 1; d.sel = 3'd2; d.op = (fn == 6'h00) ? 8'h7C : {2'b00, fn};
                d.rb = 1; d.a_sa = 1; d.wsrc = 1;
            end
        end else if (opc inside {6'h0C, 6'h0D, 6'h0E}) begin
            d.ok = 1; d.sel = 3'd1; d.op = 8'h24 + 8'(opc - 6'h0C); d.ra = 1; d.bkind = 1; d.wsrc = 2;
        end else if (opc == 6'h09) begin
            d.ok = 1; d.sel = 3'd3; d.op = 8'h21; d.ra = 1; d.bkind = 2; d.wsrc = 2;
        end else if (opc == 6'h0F) begin
            d.ok = 1; d.sel = 3'd1; d.op = 8'h25; d.bkind = 3; d.wsrc = 2;
        end
        return d;
    endfunction

    function automatic logic [31:0] fetch(input logic [4:0] r, input logic [31:0] rfv);
        if (r == 5'd0) return 32'h0;
        if (ex_we_i && ex_waddr_i == r) return ex_wdata_i;
        if (mem_we_i && mem_waddr_i == r) return mem_wdata_i;
        return rfv;
    endfunction

    function automatic bit model_stall();
        dec_t d;
        bit   dep;
        d = decode(inst_i);
        dep = (d.ra && inst_i[25:21] == ex_waddr_i) || (d.rb && inst_i[20:16] == ex_waddr_i);
        return in_valid_i && ex_load_i && ex_we_i && (ex_waddr_i != 5'd0) && dep;
    endfunction

    function automatic bit model_ready();
        return (!exp_q.v || out_ready_i) && !model_stall() && !flush_i;
    endfunction

    function automatic exp_t model_next();
        exp_t e;
        dec_t d;
        logic [15:0] imm;
        e = empty_e;
        if (rst || flush_i) return e;
        if (exp_q.v && !out_ready_i) return exp_q;
        if (!(in_valid_i && model_ready())) return e;
        d   = decode(inst_i);
        imm = inst_i[15:0];
        e.v   = 1;
        e.pc  = pc_i;
        e.iv  = d.ok;
        e.sel = d.sel;
        e.op  = d.op;
        e.wa  = (d.wsrc == 1) ? inst_i[15:11] : ((d.wsrc == 2) ? inst_i[20:16] : 5'd0);
        e.we  = d.ok && (e.wa != 5'd0);
        if (d.ra)        e.a = fetch(inst_i[25:21], rf_rdata_a_i);
        else if (d.a_sa) e.a = {27'd0, inst_i[10:6]};
        else             e.a = 32'h0;
        case (d.bkind)
            1: e.b = {16'h0, imm};
            2: e.b = {{16{imm[15]}}, imm};
            3: e.b = {imm, 16'h0};
            default: e.b = d.rb ? fetch(inst_i[20:16], rf_rdata_b_i) : 32'h0;
        endcase
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic compare_outputs();
        chk("out_valid", out_valid_o, exp_q.v);
        chk("we", we_o, exp_q.we);
        if (exp_q.v) begin
            chk("pc", pc_o, exp_q.pc);
            chk("alu_sel", alu_sel_o, exp_q.sel);
            chk("alu_op", alu_op_o, exp_q.op);
            chk("inst_valid", inst_valid_o, exp_q.iv);
            if (exp_q.iv) begin
                chk("op_a", op_a_o, exp_q.a);
                chk("op_b", op_b_o, exp_q.b);
                chk("waddr", waddr_o, exp_q.wa);
            end
        end
    endtask

    // Inputs are set at a falling edge; check combinational outputs, clock once,
    // then compare the registered outputs at the next falling edge.
    task automatic cycle();
        exp_t nxt;
        dec_t d;
        bit   rst_at_edge;
        #1;
        if (known && !rst) begin
            d = decode(inst_i);
            chk("in_ready", in_ready_o, model_ready());
            chk("rf_raddr_a", rf_raddr_a_o, inst_i[25:21]);
            chk("rf_raddr_b", rf_raddr_b_o, inst_i[20:16]);
            chk("rf_re_a", rf_re_a_o, d.ra);
            chk("rf_re_b", rf_re_b_o, d.rb);
        end
        nxt = model_next();
        rst_at_edge = rst;
        @(posedge clk);
        exp_q = nxt;
        if (rst_at_edge) known = 1;
        @(negedge clk);
        if (known) compare_outputs();
    endtask

    task automatic idle();
        flush_i = 0; in_valid_i = 0; out_ready_i = 1;
        pc_i = 32'h0; inst_i = 32'h0;
        rf_rdata_a_i = 32'h0; rf_rdata_b_i = 32'h0;
        ex_we_i = 0; ex_load_i = 0; ex_waddr_i = 5'd0; ex_wdata_i = 32'h0;
        mem_we_i = 0; mem_waddr_i = 5'd0; mem_wdata_i = 32'h0;
    endtask

    function automatic logic [31:0] r_type(input logic [4:0] s, input logic [4:0] t,
                                           input logic [4:0] d, input logic [4:0] sh,
                                           input logic [5:0] fn);
        return {6'h00, s, t, d, sh, fn};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] s,
                                           input logic [4:0] t, input logic [15:0] im);
        return {op, s, t, im};
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [5:0]  fns[10];
        logic [5:0]  ops[5];
        logic [4:0]  s, t, d, sh;
        logic [15:0] im;
        int          k;
        fns = '{6'h24, 6'h25, 6'h26, 6'h27, 6'h21, 6'h23, 6'h2A, 6'h00, 6'h02, 6'h03};
        ops = '{6'h0C, 6'h0D, 6'h0E, 6'h09, 6'h0F};
        s  = 5'($urandom_range(0, 7));
        t  = 5'($urandom_range(0, 7));
        d  = 5'($urandom_range(0, 7));
        sh = 5'($urandom);
        im = 16'($urandom);
        k  = $urandom_range(0, 16);
        if (k < 10) return r_type(s, t, d, sh, fns[k]);
        if (k < 15) return i_type(ops[k - 10], s, t, im);
        if (k == 15) return r_type(s, t, d, sh, 6'h3F);
        return i_type(6'h3F, s, t, im);
    endfunction

    initial begin
        empty_e = '{default: 0};
        exp_q = empty_e;
        rst = 1;
        idle();
        cycle();
        cycle();
        chk("rst out_valid", out_valid_o, 1'b0);
        chk("rst we", we_o, 1'b0);
        chk("rst alu_sel", alu_sel_o, 3'd0);
        chk("rst alu_op", alu_op_o, 8'h00);
        chk("rst inst_valid", inst_valid_o, 1'b0);
        rst = 0;

        // ORI r1,r0,0x1234
        in_valid_i = 1; pc_i = 32'h100; inst_i = i_type(6'h0D, 5'd0, 5'd1, 16'h1234);
        cycle();
        chk("ori out_valid", out_valid_o, 1'b1);
        chk("ori op_a", op_a_o, 32'h0);
        chk("ori op_b", op_b_o, 32'h1234);
        chk("ori waddr", waddr_o, 5'd1);
        chk("ori we", we_o, 1'b1);
        chk("ori alu_sel", alu_sel_o, 3'd1);
        chk("ori alu_op", alu_op_o, 8'h25);

        // OR r3,r1,r2: EX beats MEM for r1, r2 from register file
        pc_i = 32'h104; inst_i = r_type(5'd1, 5'd2, 5'd3, 5'd0, 6'h25);
        ex_we_i = 1; ex_waddr_i = 5'd1; ex_wdata_i = 32'hAAAA0000;
        mem_we_i = 1; mem_waddr_i = 5'd1; mem_wdata_i = 32'h5555;
        rf_rdata_a_i = 32'hDEAD; rf_rdata_b_i = 32'h0F;
        cycle();
        chk("fwd op_a", op_a_o, 32'hAAAA0000);
        chk("fwd op_b", op_b_o, 32'h0F);

        // load-use: ADDU r5,r4,r6 behind a load to r4
        idle();
        in_valid_i = 1; pc_i = 32'h108; inst_i = r_type(5'd4, 5'd6, 5'd5, 5'd0, 6'h21);
        ex_we_i = 1; ex_load_i = 1; ex_waddr_i = 5'd4; ex_wdata_i = 32'hBAD;
        #1 chk("lu in_ready", in_ready_o, 1'b0);
        cycle();
        chk("lu bubble", out_valid_o, 1'b0);
        ex_we_i = 0; ex_load_i = 0;
        mem_we_i = 1; mem_waddr_i = 5'd4; mem_wdata_i = 32'h44; rf_rdata_b_i = 32'h66;
        cycle();
        chk("lu out_valid", out_valid_o, 1'b1);
        chk("lu op_a", op_a_o, 32'h44);
        chk("lu op_b", op_b_o, 32'h66);
        chk("lu waddr", waddr_o, 5'd5);

        // backpressure hold
        idle();
        in_valid_i = 1; pc_i = 32'h10C; inst_i = r_type(5'd1, 5'd2, 5'd7, 5'd0, 6'h26);
        rf_rdata_a_i = 32'h1; rf_rdata_b_i = 32'h2;
        cycle();
        out_ready_i = 0; pc_i = 32'h110; inst_i = i_type(6'h0C, 5'd1, 5'd9, 16'h00FF);
        for (int i = 0; i < 3; i++) begin
            #1 chk("hold in_ready", in_ready_o, 1'b0);
            cycle();
            chk("hold out_valid", out_valid_o, 1'b1);
            chk("hold op_b", op_b_o, 32'h2);
            chk("hold alu_op", alu_op_o, 8'h26);
        end
        out_ready_i = 1;
        cycle();
        chk("release alu_op", alu_op_o, 8'h24);
        chk("release op_b", op_b_o, 32'hFF);

        // flush while stalled downstream
        out_ready_i = 0; flush_i = 1; pc_i = 32'h114; inst_i = i_type(6'h09, 5'd1, 5'd2, 16'hFFFF);
        #1 chk("flush in_ready", in_ready_o, 1'b0);
        cycle();
        chk("flush out_valid", out_valid_o, 1'b0);
        chk("flush we", we_o, 1'b0);
        flush_i = 0; in_valid_i = 0; out_ready_i = 1;
        cycle();
        chk("flush dropped", out_valid_o, 1'b0);

        // ADDIU sign extension and LUI
        in_valid_i = 1; rf_rdata_a_i = 32'h5;
        cycle();
        chk("addiu op_b", op_b_o, 32'hFFFFFFFF);
        chk("addiu op_a", op_a_o, 32'h5);
        inst_i = i_type(6'h0F, 5'd0, 5'd3, 16'hABCD);
        cycle();
        chk("lui op_b", op_b_o, 32'hABCD0000);
        chk("lui op_a", op_a_o, 32'h0);

        // illegal opcode, then the all-zero NOP
        inst_i = i_type(6'h3F, 5'd1, 5'd2, 16'h1234);
        cycle();
        chk("ill out_valid", out_valid_o, 1'b1);
        chk("ill inst_valid", inst_valid_o, 1'b0);
        chk("ill we", we_o, 1'b0);
        chk("ill alu_op", alu_op_o, 8'h00);
        inst_i = 32'h0;
        cycle();
        chk("nop out_valid", out_valid_o, 1'b1);
        chk("nop we", we_o, 1'b0);
        chk("nop alu_op", alu_op_o, 8'h7C);

        // reset mid-stream
        rst = 1; inst_i = i_type(6'h0D, 5'd0, 5'd1, 16'h1);
        cycle();
        chk("mrst out_valid", out_valid_o, 1'b0);
        chk("mrst we", we_o, 1'b0);
        chk("mrst alu_sel", alu_sel_o, 3'd0);
        chk("mrst inst_valid", inst_valid_o, 1'b0);
        rst = 0;

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst          = ($urandom_range(0, 99) == 0);
            flush_i      = ($urandom_range(0, 19) == 0);
            in_valid_i   = ($urandom_range(0, 9) < 8);
            out_ready_i  = ($urandom_range(0, 9) < 7);
            pc_i         = $urandom;
            inst_i       = rand_inst();
            rf_rdata_a_i = $urandom;
            rf_rdata_b_i = $urandom;
            ex_we_i      = 1'($urandom);
            ex_load_i    = ($urandom_range(0, 3) == 0);
            ex_waddr_i   = 5'($urandom_range(0, 7));
            ex_wdata_i   = $urandom;
            mem_we_i     = 1'($urandom);
            mem_waddr_i  = 5'($urandom_range(0, 7));
            mem_wdata_i  = $urandom;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
